// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR merge family: FSM encoding, width helpers,
// hat weighting and signed saturation limits.
package hdr_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_SUM  = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Signed numerator: (N+1)-bit difference times a PIX_W-bit weight, summed over exposures.
  function automatic int acc_width(input int n, input int pix_w, input int num_exp);
    return n + 1 + pix_w + clog2(num_exp);
  endfunction

  // Hat weights never exceed 2^(PIX_W-1)-1, so the weight sum fits in this width.
  function automatic int den_width(input int pix_w, input int num_exp);
    return pix_w - 1 + clog2(num_exp);
  endfunction

  function automatic int sat_pos_lim(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int sat_neg_mag(input int n);
    return 1 << (n - 1);
  endfunction

  function automatic int unsigned hat_weight(input int unsigned z, input int unsigned pix_w);
    int unsigned zmax;
    zmax = (32'd1 << pix_w) - 32'd1;
    return (z <= (zmax >> 1)) ? z : zmax - z;
  endfunction

endpackage

// File: rtl/hdr_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first.
// done marks the cycle in which the final quotient is presented on quotient.
module hdr_seq_div
  import hdr_pkg::*;
#(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;

  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W-1:0]  rem_step;
  logic [DIVIDEND_W-1:0] quo_step;

  // quo_q starts as the dividend; its MSB feeds the remainder while quotient bits shift in at the LSB.
  always_comb begin
    trial    = {rem_q, quo_q[DIVIDEND_W-1]};
    fits     = trial >= {1'b0, dvs_q};
    rem_step = fits ? DIVISOR_W'(trial - {1'b0, dvs_q}) : trial[DIVISOR_W-1:0];
    quo_step = {quo_q[DIVIDEND_W-2:0], fits};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      dvs_d  = divisor;
      quo_d  = dividend;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; blocking here would race with readers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded by start before being read.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    quo_q <= quo_d;
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign quotient = quo_step;

endmodule

// File: rtl/hdr_merge_seq.sv
// Single-channel HDR radiance merge: lE = sum(w*(g-lnt)) / sum(w) with hat
// weights, a registered multiply, a summing stage and a sequential divide.
module hdr_merge_seq
  import hdr_pkg::*;
#(
  parameter int NUM_EXP = 3,
  parameter int PIX_W   = 5,
  parameter int N       = 8,
  parameter int FP      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_EXP*PIX_W-1:0] pixel_in,
  input  logic [NUM_EXP*N-1:0]     g_in,
  input  logic [NUM_EXP*N-1:0]     lnt_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic                     out_sat,
  output logic                     out_zero_w
);

  localparam int ACC_W = acc_width(N, PIX_W, NUM_EXP);
  localparam int P_W   = N + 1 + PIX_W;
  localparam int DEN_W = den_width(PIX_W, NUM_EXP);
  localparam logic [ACC_W-1:0] POS_LIM = ACC_W'(sat_pos_lim(N));
  localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(sat_neg_mag(N));
  localparam logic [N-1:0]     POS_MAX = N'(sat_pos_lim(N));
  localparam logic [N-1:0]     NEG_MIN = N'(sat_neg_mag(N));

  // Integer weights leave the quotient in the same Q(N-FP).FP format as g and lnt.
  if (FP < 0 || FP >= N) begin : g_bad_fp
    $error("hdr_merge_seq: FP must lie in [0, N-1]");
  end

  logic [2:0]            state_q, state_d;
  logic [PIX_W-1:0]      z_q [NUM_EXP];
  logic [PIX_W-1:0]      z_d [NUM_EXP];
  logic signed [N-1:0]   g_q [NUM_EXP];
  logic signed [N-1:0]   g_d [NUM_EXP];
  logic signed [N-1:0]   lnt_q [NUM_EXP];
  logic signed [N-1:0]   lnt_d [NUM_EXP];
  logic signed [P_W-1:0] p_q [NUM_EXP];
  logic signed [P_W-1:0] p_d [NUM_EXP];
  logic [N-1:0]          out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;
  logic                  out_zero_w_q, out_zero_w_d;

  logic [PIX_W-1:0]      w [NUM_EXP];
  logic signed [N:0]     d [NUM_EXP];
  logic signed [ACC_W-1:0] num;
  logic [ACC_W-1:0]      num_abs;
  logic [DEN_W-1:0]      den;
  logic [ACC_W-1:0]      quo_neg;
  logic                  accept;
  logic                  div_start, div_busy, div_done;
  logic [ACC_W-1:0]      div_quo;

  assign accept    = (state_q == ST_IDLE) && in_valid;
  assign div_start = (state_q == ST_SUM) && (den != '0) && !div_busy;

  always_comb begin
    for (int i = 0; i < NUM_EXP; i++) begin
      z_d[i]   = accept ? pixel_in[i*PIX_W +: PIX_W] : z_q[i];
      g_d[i]   = accept ? $signed(g_in[i*N +: N]) : g_q[i];
      lnt_d[i] = accept ? $signed(lnt_in[i*N +: N]) : lnt_q[i];
      w[i]     = PIX_W'(hat_weight(32'(z_q[i]), PIX_W));
      d[i]     = (N+1)'(g_q[i]) - (N+1)'(lnt_q[i]);
      // Weight MSB is always zero, so the signed reinterpretation keeps it positive.
      p_d[i]   = (state_q == ST_MUL) ? P_W'($signed(w[i])) * P_W'(d[i]) : p_q[i];
    end
  end

  always_comb begin
    num = '0;
    den = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      num = num + ACC_W'(p_q[i]);
      den = den + DEN_W'(w[i]);
    end
    num_abs = num[ACC_W-1] ? ACC_W'(-num) : ACC_W'(num);
  end

  hdr_seq_div #(
    .DIVIDEND_W (ACC_W),
    .DIVISOR_W  (DEN_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num_abs),
    .divisor  (den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    out_zero_w_d = out_zero_w_q;
    quo_neg      = -div_quo;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_MUL;
      ST_MUL:  state_d = ST_SUM;
      ST_SUM: begin
        if (den == '0) begin
          state_d      = ST_DONE;
          out_data_d   = '0;
          out_sat_d    = 1'b0;
          out_zero_w_d = 1'b1;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d      = ST_DONE;
          out_zero_w_d = 1'b0;
          // p_q is frozen after MUL, so num still carries the sign of this sample.
          if (num[ACC_W-1]) begin
            out_sat_d  = div_quo > NEG_LIM;
            out_data_d = (div_quo > NEG_LIM) ? NEG_MIN : quo_neg[N-1:0];
          end else begin
            out_sat_d  = div_quo > POS_LIM;
            out_data_d = (div_quo > POS_LIM) ? POS_MAX : div_quo[N-1:0];
          end
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      out_zero_w_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      out_zero_w_q <= out_zero_w_d;
    end
  end

  always_ff @(posedge clk) begin
    z_q   <= z_d;
    g_q   <= g_d;
    lnt_q <= lnt_d;
    p_q   <= p_d;
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign out_zero_w = out_zero_w_q;

endmodule
